imem_sync_fetch: RTL and testbench



---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_ram_1r1w.sv | 34 +++
 rtl/imem_sync_fetch.sv | 174 +++++++++++++++++
 tb/tb_imem_sync_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg - shared types and constants for imem_sync_fetch       rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10
  } fault_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/imem_ram_1r1w.sv
// ---------------------------------------------------------------------------
// imem_ram_1r1w - DEPTH x WIDTH array, sync write, sync read with enable  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_ram_1r1w #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read data holds between enables so a stalled response stays stable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_sync_fetch.sv
// ---------------------------------------------------------------------------
// imem_sync_fetch - loadable instruction store with a 1-cycle handshaked fetch port  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_sync_fetch
  import imem_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter int               DEPTH     = 256,
  parameter logic [XLEN-1:0]  BASE_ADDR = '0,
  parameter logic [XLEN-1:0]  NOP_INST  = XLEN'(NOP)
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_load_en,
  input  logic                     i_load_we,
  input  logic [$clog2(DEPTH)-1:0] i_load_addr,
  input  logic [XLEN-1:0]          i_load_data,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [XLEN-1:0]          i_req_addr,
  input  logic                     i_flush,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [XLEN-1:0]          o_rsp_inst,
  output logic [XLEN-1:0]          o_rsp_addr,
  output logic [1:0]               o_rsp_fault,
  output logic [1:0]               o_state
);

  localparam int AW = $clog2(DEPTH);

  state_e          state;
  state_e          state_next;
  logic [AW-1:0]   clr_cnt;
  logic            clr_last;
  logic            req_ready;
  logic            accept;

  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] word_idx;
  fault_e          req_fault;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_addr;
  fault_e          rsp_fault;

  logic            load_in_range;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [XLEN-1:0] ram_wdata;
  logic            ram_re;
  logic [XLEN-1:0] ram_rdata;

  assign clr_last = (clr_cnt == AW'(DEPTH - 1));

  // Load indices only need a bounds check when DEPTH leaves unused codes.
  if ((1 << AW) == DEPTH) begin : g_load_pow2
    assign load_in_range = 1'b1;
  end else begin : g_load_npow2
    assign load_in_range = ({1'b0, i_load_addr} < (AW+1)'(DEPTH));
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    unique case (state)
      CLEAR: begin
        if (clr_last) state_next = LOAD;
      end
      LOAD: begin
        if (!i_load_en) state_next = RUN;
      end
      RUN: begin
        req_ready = !i_flush && !i_load_en && (!rsp_valid || i_rsp_ready);
        if (i_load_en) state_next = DRAIN;
      end
      DRAIN: begin
        if (!rsp_valid) state_next = LOAD;
      end
      default: state_next = CLEAR;
    endcase
  end

  assign accept = i_req_valid && req_ready;

  // Unsigned offset; addresses below BASE_ADDR are rejected explicitly so
  // the wrapped difference can never alias onto a valid word.
  assign offset   = i_req_addr - BASE_ADDR;
  assign word_idx = offset >> 2;

  always_comb begin
    req_fault = FLT_NONE;
    if (i_req_addr[1:0] != 2'b00) begin
      req_fault = FLT_MISALIGN;
    end else if ((i_req_addr < BASE_ADDR) || (word_idx >= XLEN'(DEPTH))) begin
      req_fault = FLT_RANGE;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_cnt;
    ram_wdata = NOP_INST;
    case (state)
      CLEAR: ram_we = 1'b1;
      LOAD: begin
        ram_we    = i_load_we && load_in_range;
        ram_waddr = i_load_addr;
        ram_wdata = i_load_data;
      end
      default: ram_we = 1'b0;
    endcase
  end

  assign ram_re = accept && (req_fault == FLT_NONE);

  imem_ram_1r1w #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (word_idx[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Flush beats both a new accept and a consume; accept beats consume.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_fault <= FLT_NONE;
    end else if (i_flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= i_req_addr;
      rsp_fault <= req_fault;
    end else if (i_rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign o_req_ready = req_ready;
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_addr  = rsp_addr;
  assign o_rsp_fault = rsp_fault;
  assign o_state     = state;

  // RAM has no reset, so the instruction is masked until a response exists.
  assign o_rsp_inst = !rsp_valid               ? '0        :
                      (rsp_fault == FLT_NONE)  ? ram_rdata : NOP_INST;

endmodule

`default_nettype wire

// File: tb/tb_imem_sync_fetch.sv
// ---------------------------------------------------------------------------
// tb_imem_sync_fetch - scoreboard bench with a word-array reference model  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_sync_fetch;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] NOPI  = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [1:0]  fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        load_en, load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_inst, rsp_addr;
  logic [1:0]  rsp_fault, state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [DEPTH];
  exp_t        q[$];
  logic        mon_en    = 1'b0;
  logic        bench_run = 1'b0;
  logic        exp_valid = 1'b0;

  imem_sync_fetch dut (
    .i_clk       (clk),
    .i_arst_n    (arst_n),
    .i_load_en   (load_en),
    .i_load_we   (load_we),
    .i_load_addr (load_addr),
    .i_load_data (load_data),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_flush     (flush),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_inst  (rsp_inst),
    .o_rsp_addr  (rsp_addr),
    .o_rsp_fault (rsp_fault),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_fetch(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    if (a % 4 != 0) begin
      e.fault = 2'd1; e.inst = NOPI;
    end else if (a < BASE || (a - BASE) / 4 >= DEPTH) begin
      e.fault = 2'd2; e.inst = NOPI;
    end else begin
      e.fault = 2'd0; e.inst = model_mem[(a - BASE) / 4];
    end
    return e;
  endfunction

  // Scoreboard monitor: compare what the DUT presents, then advance the model.
  always @(negedge clk) begin
    if (mon_en) begin
      logic acc;
      check("rsp_valid", rsp_valid, exp_valid);
      check("req_ready", req_ready,
            bench_run && !flush && !load_en && (!exp_valid || rsp_ready));
      if (rsp_valid) begin
        if (q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          check("rsp_inst", rsp_inst, q[0].inst);
          check("rsp_addr", rsp_addr, q[0].addr);
          check("rsp_fault", rsp_fault, q[0].fault);
        end
      end
      acc = req_valid && req_ready;
      if (exp_valid && (flush || rsp_ready) && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(model_fetch(req_addr));
      if (flush)                       exp_valid = 1'b0;
      else if (acc)                    exp_valid = 1'b1;
      else if (exp_valid && rsp_ready) exp_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string name);
    int n = 0;
    while (state !== s && n < limit) begin tick(); n++; end
    check(name, state, s);
  endtask

  task automatic fetch(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1; req_addr = a;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    if (!req_ready) check("fetch_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] idx, input logic [31:0] d, input logic last);
    load_we = 1'b1; load_addr = idx; load_data = d;
    if (last) load_en = 1'b0;
    model_mem[idx] = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic go_load();
    load_en = 1'b1; bench_run = 1'b0;
    wait_state(2'b01, 50, "enter_load");
  endtask

  task automatic go_run();
    load_en = 1'b0;
    wait_state(2'b10, 10, "enter_run");
    bench_run = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_inst", rsp_inst, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    check("rst_rsp_fault", rsp_fault, 0);
    check("rst_state", state, 2'b00);
  endtask

  task automatic model_reset();
    mon_en = 1'b0; bench_run = 1'b0; exp_valid = 1'b0;
    q.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOPI;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arst_n = 1'b1; load_en = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b1;
    model_reset();
    #3 arst_n = 1'b0;
    #1 check_reset_outputs();
    #28;
    tick();
    arst_n = 1'b1;
    mon_en = 1'b1;

    n = 0;
    while (state === 2'b00 && n < 400) begin tick(); n++; end
    check("clear_cycles", n, 256);
    check("after_clear_load", state, 2'b01);
    go_run();
    fetch(32'h40);
    repeat (2) tick();

    go_load();
    load_word(8'd1, 32'h0020_81b3, 1'b0);
    load_word(8'd2, 32'h4052_0333, 1'b1);
    go_run();
    fetch(32'h4);
    fetch(32'h8);
    repeat (2) tick();

    // Backpressure: 0x8 must wait until the stalled 0x4 is consumed.
    rsp_ready = 1'b0;
    fetch(32'h4);
    req_valid = 1'b1; req_addr = 32'h8;
    repeat (3) tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("accept_on_release", req_ready, 1);
    tick();
    req_valid = 1'b0;
    repeat (2) tick();

    fetch(32'h6);
    fetch(32'h400);
    fetch(32'h402);
    fetch(32'h3fc);
    fetch(32'hffff_fffc);
    repeat (2) tick();

    rsp_ready = 1'b0;
    fetch(32'h4);
    req_valid = 1'b1; req_addr = 32'h8; flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_req", req_ready, 0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_clears_valid", rsp_valid, 0);
    rsp_ready = 1'b1;
    repeat (2) tick();

    go_load();
    for (int i = 0; i < 64; i++) load_word(8'($urandom_range(0, DEPTH-1)), $urandom, 1'b0);
    go_run();
    for (int c = 0; c < 500; c++) begin
      int r;
      r = $urandom_range(0, 9);
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 8);
      if (r < 7)       req_addr = BASE + 4 * $urandom_range(0, DEPTH-1);
      else if (r == 7) req_addr = BASE + 4 * $urandom_range(0, DEPTH-1) + $urandom_range(1, 3);
      else if (r == 8) req_addr = BASE + 4 * $urandom_range(DEPTH, 4*DEPTH);
      else             req_addr = $urandom;
      tick();
    end
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (3) tick();

    rsp_ready = 1'b0;
    fetch(32'h8);
    load_en = 1'b1; bench_run = 1'b0;
    tick();
    check("drain_entered", state, 2'b11);
    tick();
    check("drain_holds", state, 2'b11);
    rsp_ready = 1'b1;
    wait_state(2'b01, 5, "drain_to_load");

    go_run();
    rsp_ready = 1'b0;
    fetch(32'h8);
    load_en = 1'b1; bench_run = 1'b0;
    tick();
    check("drain_before_reset", state, 2'b11);
    #2;
    model_reset();
    arst_n = 1'b0;
    #1 check_reset_outputs();
    #10;
    tick();
    arst_n = 1'b1; load_en = 1'b0; rsp_ready = 1'b1;
    mon_en = 1'b1;
    wait_state(2'b10, 300, "rerun_after_reset");
    bench_run = 1'b1;
    fetch(32'h4);
    repeat (3) tick();

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
